// File: rtl/trap_controller_if.sv
// Pipeline <-> trap controller signal bundle.
// master: pipeline side (raises faults, acks flush, issues mret).
// slave:  trap controller side.
interface trap_controller_if #(
   parameter int XLEN       = 64,
   parameter int NUM_CAUSES = 4,
   parameter int CAUSE_W    = 3
);
   logic [NUM_CAUSES-1:0]      cause_req;
   logic [NUM_CAUSES*XLEN-1:0] cause_pc;
   logic [NUM_CAUSES*XLEN-1:0] cause_tval;
   logic                       flush_ack;
   logic                       mret;
   logic                       trap_valid;
   logic [CAUSE_W-1:0]         trap_type;
   logic [XLEN-1:0]            mepc;
   logic [XLEN-1:0]            mtval;
   logic [XLEN-1:0]            mtvec_addr;
   logic                       flush_req;
   logic                       in_handler;
   logic                       ret_valid;

   modport master (
      output cause_req, cause_pc, cause_tval, flush_ack, mret,
      input  trap_valid, trap_type, mepc, mtval, mtvec_addr,
             flush_req, in_handler, ret_valid
   );

   modport slave (
      input  cause_req, cause_pc, cause_tval, flush_ack, mret,
      output trap_valid, trap_type, mepc, mtval, mtvec_addr,
             flush_req, in_handler, ret_valid
   );
endinterface

// File: rtl/trap_controller.sv
// Trap controller: edge-detects fault requests, picks one by fixed priority,
// captures mcause/mepc/mtval, runs the flush handshake and queues late faults.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | no trap in progress; takes the lowest pending/new cause
// FLUSH   | flush_req high, waiting for flush_ack
// HANDLER | handler running (in_handler high), waiting for mret
// RETURN  | one-cycle gap after mret before the next trap can be taken
module trap_controller #(
   parameter int XLEN         = 64,
   parameter int NUM_CAUSES   = 4,
   parameter int CAUSE_W      = 3,
   parameter int MTVEC_BASE   = 472,
   parameter int MTVEC_STRIDE = 8
) (
   input logic             clk,
   input logic             rstn,
   trap_controller_if.slave bus
);

   typedef enum logic [1:0] {IDLE, FLUSH, HANDLER, RETURN} state_t;

   state_t                state_q, state_d;
   logic [NUM_CAUSES-1:0] req_dly_q;
   logic [NUM_CAUSES-1:0] pending_q, pending_d;
   logic [NUM_CAUSES-1:0] req_edge, cand;
   logic [CAUSE_W-1:0]    sel_idx;
   logic [XLEN-1:0]       sel_pc, sel_tval;
   logic [CAUSE_W-1:0]    trap_type_q, trap_type_d;
   logic [XLEN-1:0]       mepc_q, mepc_d;
   logic [XLEN-1:0]       mtval_q, mtval_d;
   logic [XLEN-1:0]       mtvec_q, mtvec_d;
   logic                  trap_valid_q, trap_valid_d;
   logic                  flush_req_q, flush_req_d;
   logic                  in_handler_q, in_handler_d;
   logic                  ret_valid_q, ret_valid_d;

   assign req_edge = bus.cause_req & ~req_dly_q;
   assign cand     = req_edge | pending_q;

   // Lowest set bit of cand wins; scanning downward leaves the lowest index.
   always_comb begin
      sel_idx = '0;
      for (int i = NUM_CAUSES - 1; i >= 0; i--) begin
         if (cand[i]) sel_idx = CAUSE_W'(i);
      end
   end

   // Mux out the faulting PC and trap value of the selected cause.
   always_comb begin
      sel_pc   = '0;
      sel_tval = '0;
      for (int i = 0; i < NUM_CAUSES; i++) begin
         if (sel_idx == CAUSE_W'(i)) begin
            sel_pc   = bus.cause_pc[i*XLEN +: XLEN];
            sel_tval = bus.cause_tval[i*XLEN +: XLEN];
         end
      end
   end

   // Next-state and output logic; late faults always accumulate into pending.
   always_comb begin
      state_d      = state_q;
      pending_d    = pending_q | req_edge;
      trap_type_d  = trap_type_q;
      mepc_d       = mepc_q;
      mtval_d      = mtval_q;
      mtvec_d      = mtvec_q;
      trap_valid_d = 1'b0;
      flush_req_d  = flush_req_q;
      in_handler_d = in_handler_q;
      ret_valid_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (cand != '0) begin
               state_d      = FLUSH;
               trap_type_d  = sel_idx + CAUSE_W'(1);
               mepc_d       = sel_pc;
               mtval_d      = sel_tval;
               mtvec_d      = XLEN'(MTVEC_BASE) + XLEN'(sel_idx) * XLEN'(MTVEC_STRIDE);
               trap_valid_d = 1'b1;
               flush_req_d  = 1'b1;
               pending_d    = cand & ~(NUM_CAUSES'(1) << sel_idx);
            end
         end
         FLUSH: begin
            if (bus.flush_ack) begin
               state_d      = HANDLER;
               flush_req_d  = 1'b0;
               in_handler_d = 1'b1;
            end
         end
         HANDLER: begin
            if (bus.mret) begin
               state_d      = RETURN;
               in_handler_d = 1'b0;
               ret_valid_d  = 1'b1;
               trap_type_d  = '0;
            end
         end
         RETURN: begin
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // State and output registers; reset aborts any trap in progress.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q      <= IDLE;
         req_dly_q    <= '0;
         pending_q    <= '0;
         trap_type_q  <= '0;
         mepc_q       <= '0;
         mtval_q      <= '0;
         mtvec_q      <= '0;
         trap_valid_q <= 1'b0;
         flush_req_q  <= 1'b0;
         in_handler_q <= 1'b0;
         ret_valid_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         req_dly_q    <= bus.cause_req;
         pending_q    <= pending_d;
         trap_type_q  <= trap_type_d;
         mepc_q       <= mepc_d;
         mtval_q      <= mtval_d;
         mtvec_q      <= mtvec_d;
         trap_valid_q <= trap_valid_d;
         flush_req_q  <= flush_req_d;
         in_handler_q <= in_handler_d;
         ret_valid_q  <= ret_valid_d;
      end
   end

   assign bus.trap_valid = trap_valid_q;
   assign bus.trap_type  = trap_type_q;
   assign bus.mepc       = mepc_q;
   assign bus.mtval      = mtval_q;
   assign bus.mtvec_addr = mtvec_q;
   assign bus.flush_req  = flush_req_q;
   assign bus.in_handler = in_handler_q;
   assign bus.ret_valid  = ret_valid_q;

endmodule

// File: tb/tb_trap_controller.sv
// Bench for trap_controller: table of single-cause traps plus hand-written
// sequences; every trap_valid pulse is checked against a scoreboard queue.
module tb_trap_controller;

   localparam int XLEN = 64;
   localparam int NC   = 4;
   localparam int CW   = 3;

   typedef struct {
      logic [CW-1:0]   ttype;
      logic [XLEN-1:0] mepc;
      logic [XLEN-1:0] mtval;
      logic [XLEN-1:0] mtvec;
   } exp_t;

   typedef struct {
      int              idx;
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] tval;
      int              ack_dly;
      int              mret_dly;
      bit              stray;
   } vec_t;

   logic clk;
   logic rstn;
   int   checks   = 0;
   int   failures = 0;
   exp_t sb[$];
   vec_t vecs[4];

   trap_controller_if #(.XLEN(XLEN), .NUM_CAUSES(NC), .CAUSE_W(CW)) bus ();

   trap_controller dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic set_src(input int idx, input logic [63:0] pc, input logic [63:0] tval);
      bus.cause_pc[idx*XLEN +: XLEN]   = pc;
      bus.cause_tval[idx*XLEN +: XLEN] = tval;
   endtask

   task automatic push_exp(input int idx, input logic [63:0] pc, input logic [63:0] tval);
      exp_t e;
      e.ttype = CW'(idx + 1);
      e.mepc  = pc;
      e.mtval = tval;
      e.mtvec = 64'(472 + 8 * idx);
      sb.push_back(e);
   endtask

   task automatic wait_trap(input int budget);
      int n = 0;
      do begin
         tick(1);
         n++;
      end while (!bus.trap_valid && n < budget);
      check("trap_taken", bus.trap_valid, 1);
   endtask

   task automatic service(input int ack_dly, input int mret_dly, input bit stray);
      check("flush_req_set", bus.flush_req, 1);
      for (int k = 0; k < ack_dly; k++) begin
         tick(1);
         check("flush_req_hold", bus.flush_req, 1);
         check("trap_valid_one_cycle", bus.trap_valid, 0);
      end
      bus.flush_ack = 1'b1;
      tick(1);
      bus.flush_ack = 1'b0;
      check("flush_req_drop", bus.flush_req, 0);
      check("in_handler_rise", bus.in_handler, 1);
      if (stray) begin
         bus.flush_ack = 1'b1;
         tick(1);
         bus.flush_ack = 1'b0;
         check("stray_ack_in_handler", bus.in_handler, 1);
         check("stray_ack_no_flush", bus.flush_req, 0);
         check("stray_ack_no_ret", bus.ret_valid, 0);
      end
      for (int k = 0; k < mret_dly; k++) begin
         tick(1);
         check("in_handler_hold", bus.in_handler, 1);
      end
      bus.mret = 1'b1;
      tick(1);
      bus.mret = 1'b0;
      check("ret_valid_pulse", bus.ret_valid, 1);
      check("ret_trap_type", bus.trap_type, 0);
      check("ret_in_handler", bus.in_handler, 0);
      tick(1);
      check("ret_valid_one_cycle", bus.ret_valid, 0);
   endtask

   // Scoreboard: every trap_valid pulse must match the oldest expectation.
   always @(negedge clk) begin
      if (bus.trap_valid === 1'b1) begin
         if (sb.size() == 0) begin
            check("unexpected_trap", 1, 0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("trap_type", 64'(bus.trap_type), 64'(e.ttype));
            check("mepc", bus.mepc, e.mepc);
            check("mtval", bus.mtval, e.mtval);
            check("mtvec_addr", bus.mtvec_addr, e.mtvec);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int cnt;
      vecs[0] = '{1, 64'h1004, 64'h13, 3, 5, 1'b0};
      vecs[1] = '{0, 64'h2000, 64'hdead_beef, 0, 0, 1'b0};
      vecs[2] = '{2, 64'h3000, 64'h8000_0000_0000_0004, 1, 2, 1'b0};
      vecs[3] = '{3, 64'hffff_ffff_ffff_fff0, 64'h55, 2, 1, 1'b1};

      rstn           = 1'b0;
      bus.cause_req  = '0;
      bus.cause_pc   = '0;
      bus.cause_tval = '0;
      bus.flush_ack  = 1'b0;
      bus.mret       = 1'b0;
      #1;
      check("rst_trap_valid", bus.trap_valid, 0);
      check("rst_trap_type", bus.trap_type, 0);
      check("rst_mepc", bus.mepc, 0);
      check("rst_mtvec", bus.mtvec_addr, 0);
      check("rst_flush_req", bus.flush_req, 0);
      check("rst_in_handler", bus.in_handler, 0);
      tick(2);
      rstn = 1'b1;
      tick(1);

      // Single-cause traps from the table.
      foreach (vecs[v]) begin
         set_src(vecs[v].idx, vecs[v].pc, vecs[v].tval);
         push_exp(vecs[v].idx, vecs[v].pc, vecs[v].tval);
         bus.cause_req = NC'(1) << vecs[v].idx;
         wait_trap(4);
         service(vecs[v].ack_dly, vecs[v].mret_dly, vecs[v].stray);
         bus.cause_req = '0;
         tick(1);
      end

      // Simultaneous edges on causes 0 and 2: second taken from pending.
      set_src(0, 64'h2000, 64'haa);
      set_src(2, 64'h3000, 64'hbb);
      push_exp(0, 64'h2000, 64'haa);
      push_exp(2, 64'h3000, 64'hbb);
      bus.cause_req = 4'b0101;
      wait_trap(4);
      service(1, 1, 1'b0);
      wait_trap(3);
      service(0, 0, 1'b0);
      bus.cause_req = '0;
      tick(2);
      check("sb_drained_simul", 64'(sb.size()), 0);

      // Level held high gives one trap; a fresh edge in HANDLER is queued.
      set_src(0, 64'h4000, 64'hcc);
      push_exp(0, 64'h4000, 64'hcc);
      bus.cause_req = 4'b0001;
      cnt = 0;
      for (int k = 0; k < 20; k++) begin
         tick(1);
         if (bus.trap_valid) cnt++;
      end
      check("held_level_pulses", 64'(cnt), 1);
      check("held_flush_req", bus.flush_req, 1);
      bus.flush_ack = 1'b1;
      tick(1);
      bus.flush_ack = 1'b0;
      check("held_in_handler", bus.in_handler, 1);
      bus.cause_req = 4'b0000;
      tick(1);
      push_exp(0, 64'h4000, 64'hcc);
      bus.cause_req = 4'b0001;
      tick(1);
      check("queued_no_nested", bus.trap_valid, 0);
      bus.mret = 1'b1;
      tick(1);
      bus.mret = 1'b0;
      check("held_ret_valid", bus.ret_valid, 1);
      wait_trap(4);
      service(0, 0, 1'b0);
      bus.cause_req = '0;
      tick(1);

      // Reset during FLUSH with a pending cause behind it.
      set_src(1, 64'h5000, 64'hdd);
      push_exp(1, 64'h5000, 64'hdd);
      bus.cause_req = 4'b0010;
      wait_trap(4);
      bus.cause_req = 4'b0110;
      tick(1);
      check("pre_rst_flush_req", bus.flush_req, 1);
      rstn = 1'b0;
      #1;
      check("mid_rst_flush_req", bus.flush_req, 0);
      check("mid_rst_trap_type", bus.trap_type, 0);
      check("mid_rst_mepc", bus.mepc, 0);
      check("mid_rst_mtval", bus.mtval, 0);
      check("mid_rst_mtvec", bus.mtvec_addr, 0);
      check("mid_rst_in_handler", bus.in_handler, 0);
      check("mid_rst_ret_valid", bus.ret_valid, 0);
      bus.cause_req = '0;
      tick(2);
      rstn = 1'b1;
      cnt = 0;
      for (int k = 0; k < 8; k++) begin
         tick(1);
         if (bus.trap_valid || bus.flush_req) cnt++;
      end
      check("post_rst_no_trap", 64'(cnt), 0);

      // mret while IDLE is ignored.
      bus.mret = 1'b1;
      tick(1);
      bus.mret = 1'b0;
      check("idle_mret_ret_valid", bus.ret_valid, 0);
      check("idle_mret_in_handler", bus.in_handler, 0);
      check("idle_mret_flush_req", bus.flush_req, 0);
      check("idle_mret_trap_valid", bus.trap_valid, 0);
      tick(2);

      check("sb_drained_final", 64'(sb.size()), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/trap_controller.md
Name: trap_controller

Overview:
- Parametrised trap controller for the RV64I core, successor to the single-cycle trap detector.
- Accepts NUM_CAUSES level-sensitive fault requests from the pipeline and rising-edge detects each one.
- Selects one cause by fixed priority, then captures mcause, mepc and mtval and computes the vector address.
- Runs a pipeline-flush handshake, tracks handler residency until mret, and queues faults that arrive while a trap is in progress.

Parameters:
- XLEN, 64, data/address width.
- NUM_CAUSES, 4, number of fault request lines; bit 0 has highest priority.
- CAUSE_W, 3, width of trap_type; must satisfy 2^CAUSE_W > NUM_CAUSES.
- MTVEC_BASE, 472, vector address of cause index 0.
- MTVEC_STRIDE, 8, byte spacing between consecutive cause vectors.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rstn  input  1  asynchronous active-low reset.
- cause_req  input  NUM_CAUSES  level fault requests; index 0 = load/store access fault, 1 = illegal instruction, 2 = instruction access fault.
- cause_pc  input  NUM_CAUSES*XLEN  flattened faulting PC per cause; slice i is [i*XLEN +: XLEN].
- cause_tval  input  NUM_CAUSES*XLEN  flattened trap value per cause (bad address or instruction).
- flush_ack  input  1  pipeline confirms the flush is complete.
- mret  input  1  return-from-handler strobe.
- trap_valid  output  1  one-cycle pulse when a trap is taken.
- trap_type  output  CAUSE_W  mcause; 0 = no trap, otherwise selected index + 1.
- mepc  output  XLEN  captured faulting PC.
- mtval  output  XLEN  captured trap value.
- mtvec_addr  output  XLEN  handler entry address.
- flush_req  output  1  request pipeline flush.
- in_handler  output  1  high while the handler executes.
- ret_valid  output  1  one-cycle pulse; PC redirect target is mepc.

Behaviour:
- Reset (rstn low, asynchronous): all outputs 0; state IDLE; pending 0; req_d 0.
  - Reset mid-operation aborts any trap in progress immediately, with no flush_req or ret_valid emitted.
  - Because req_d resets to 0, a cause_req held high across reset release is seen as an edge on the first clock.
- Edge detection: edge[i] = cause_req[i] & ~req_d[i]; req_d <= cause_req every clock. A level held high produces exactly one edge.
- Candidate vector: cand = edge | pending. Selected index s = lowest set bit of cand.
- States: IDLE, FLUSH, HANDLER, RETURN.
- IDLE:
  - If cand != 0, the next clock performs all of the following and moves to FLUSH:
    - trap_type <= s+1
    - mepc <= cause_pc[s]
    - mtval <= cause_tval[s]
    - mtvec_addr <= MTVEC_BASE + s*MTVEC_STRIDE, computed at XLEN width with no truncation
    - trap_valid <= 1 for one cycle
    - flush_req <= 1
    - pending <= cand with bit s cleared
  - Latency: edge present in cycle t gives trap_valid high in cycle t+1.
- FLUSH:
  - flush_req stays high until flush_ack is sampled high.
  - On that clock: flush_req <= 0, in_handler <= 1, go to HANDLER.
  - flush_ack is allowed in the first FLUSH cycle, giving minimum FLUSH residency of 1 cycle.
- HANDLER:
  - in_handler stays high.
  - On mret: in_handler <= 0, ret_valid <= 1 for one cycle, trap_type <= 0, go to RETURN.
  - mepc, mtval and mtvec_addr keep their values.
- RETURN: one cycle, then IDLE. The next trap can be taken from IDLE on the following clock.
- Faults outside IDLE: edges in FLUSH, HANDLER or RETURN set the matching pending bits (pending |= edge). No nested trap is taken. Queued causes are serviced in priority order after return.
- mret outside HANDLER is ignored; flush_ack outside FLUSH is ignored.
- Simultaneous edges: lowest index wins; the losers go into pending and are taken one per trap sequence.
- Edge on a cause already pending: no double counting; the bit simply stays set.

Test Plan:
- Edge on cause_req[1] with cause_pc[1]=0x1004 and cause_tval[1]=0x00000013 → next cycle:
  - trap_valid=1, trap_type=2, mepc=0x1004, mtval=0x13, mtvec_addr=480, flush_req=1.
- flush_ack after 3 cycles, then mret 5 cycles later → flush_req drops on the ack clock and in_handler rises; then:
  - ret_valid pulses once, trap_type=0, state returns to IDLE two cycles after mret.
- cause_req=4'b0101 rising together (pc0=0x2000, pc2=0x3000) → first trap trap_type=1, mtvec_addr=472, mepc=0x2000.
  - After mret and RETURN, a second trap follows with trap_type=3, mtvec_addr=488, mepc=0x3000, with no new edge needed.
- cause_req[0] held high for 20 cycles → exactly one trap_valid pulse.
  - A new edge on cause_req[0] arriving during HANDLER is queued and retaken after return.
- Assert rstn low during FLUSH with flush_req=1 → all outputs 0 asynchronously and pending cleared.
  - After release with cause_req all low, no trap occurs.
- mret while IDLE and flush_ack while HANDLER → no state change and no pulses.
